bytewrite_sdp_ram_clr: RTL and testbench
========================================

Name: bytewrite_sdp_ram_clr

Overview:
- Simple dual-port RAM (one write port, one read port) with per-column (byte) write enables, on a single clock.
- Successor to the team's single-port byte-write RAM. Adds:
  - separate read and write addresses;
  - selectable read latency (1 or 2 cycles) with an `rvalid` strobe;
  - selectable read-during-write behaviour;
  - a post-reset zero-fill state machine.
- Used as cache data/tag storage where lines must read as zero after reset.

Parameters:
- COL_WIDTH, 8, bits per write-enable column.
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 128, word width in bits; must be a multiple of COL_WIDTH.
- NUM_COL, DATA_WIDTH/COL_WIDTH, number of columns (derived).
- READ_LATENCY, 1, cycles from `ren` to `rvalid`/`rdata`; legal values 1 or 2.
- RDW_NEW, 0, read-during-write to the same address. 0 = return old data; 1 = return merged new data.
- CLEAR_ON_RESET, 1, when 1, zero-fill every entry after reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- wen  in  NUM_COL  per-column write enable; column i is bits [i*COL_WIDTH +: COL_WIDTH].
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- ren  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- rdata  out  DATA_WIDTH  read data; valid when `rvalid`=1.
- rvalid  out  1  one-cycle strobe, one per accepted read.
- init_done  out  1  high when the RAM accepts accesses.

Behaviour:
- Reset (`resetn`=0 at posedge):
  - state <= CLEAR if CLEAR_ON_RESET=1, else READY.
  - clr_cnt <= 0.
  - rdata <= 0; rvalid <= 0; all read pipeline valids <= 0; init_done <= 0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes all-zero to entry clr_cnt, then increments clr_cnt.
  - After writing entry 2**ADDR_WIDTH-1, moves to READY. The fill takes exactly 2**ADDR_WIDTH cycles.
  - `wen` and `ren` are ignored; no `rvalid` is produced.
- READY state:
  - init_done = 1. With CLEAR_ON_RESET=0, init_done rises the first cycle after reset deasserts.
  - READY is terminal until the next reset.
- Write (READY): at posedge, each column i with wen[i]=1 takes wdata's column i; other columns keep their value. wen=0 means no write.
- Read (READY, ren=1): raddr is sampled at the posedge.
  - READY_LATENCY=1: rdata is registered at that edge; rvalid=1 in the following cycle.
  - READ_LATENCY=2: a second output register is added; rdata/rvalid appear one cycle later.
  - Back-to-back reads are accepted every cycle. Full throughput, no stall.
- rdata holds its last value when no read completes; it is not zeroed.
- Read-during-write (ren=1, |wen, raddr==waddr, same cycle):
  - RDW_NEW=0: returns the pre-write word.
  - RDW_NEW=1: returns a merged word: columns with wen[i]=1 come from wdata, all others from the old word.
- Read and write to different addresses in the same cycle are independent.
- No forwarding across cycles: a write at cycle t is visible to a read issued at t+1 or later.
- Reset asserted mid-CLEAR: the fill restarts from entry 0.
- Reset asserted with reads in flight: the reads are squashed and no rvalid is produced for them.
- ren or wen asserted on the same cycle reset deasserts with CLEAR_ON_RESET=0: ignored. First access is accepted when init_done=1.
- waddr/raddr are full-range; no wrap logic is needed beyond natural width.

Test Plan:
- Clear sequence. Defaults, reset 3 cycles, release:
  - init_done stays 0 for 256 cycles, then becomes 1;
  - ren during CLEAR produces no rvalid;
  - after init_done, reads of addresses 0x00, 0x7F and 0xFF return 128'h0.
- Byte-write merge. Write 0x10 with full wen and data 128'h00112233_44556677_8899AABB_CCDDEEFF, then write 0x10 with wen=16'h0001 and data 0x...A5:
  - a read of 0x10 returns ...CCDDEEA5;
  - rvalid comes 1 cycle after ren (READ_LATENCY=1), and 2 cycles after with READ_LATENCY=2.
- Read-during-write. Entry 0x20 holds 128'h1; same cycle, wen=16'hFFFF with data 128'h2 and ren at 0x20:
  - RDW_NEW=0 returns 128'h1;
  - RDW_NEW=1 returns 128'h2;
  - a following read returns 128'h2 in both modes.
- Streaming. 8 consecutive ren cycles, addresses 0..7, each preloaded with its own address:
  - 8 consecutive rvalid pulses, with rdata=0..7 in order;
  - rdata holds 7 after the stream ends.
- Reset mid-op:
  - Reset at clear cycle 100: clr_cnt restarts, and init_done occurs 256 cycles after release.
  - Reset while 2 reads are pending (READ_LATENCY=2): no rvalid is observed afterwards.
- CLEAR_ON_RESET=0: init_done=1 one cycle after reset release, and a write then read at 0x05 round-trips correctly.

Source files
------------

// File: rtl/bytewrite_sdp_ram_clr.sv
// Simple dual-port RAM with per-column write enables, 1- or 2-cycle registered
// reads, selectable read-during-write data and an optional post-reset zero fill.
module bytewrite_sdp_ram_clr #(
    parameter int COL_WIDTH      = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 128,
    parameter int NUM_COL        = DATA_WIDTH / COL_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter bit RDW_NEW        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_COL-1:0]    wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  init_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_go;

    // init_done is registered alongside the state, so accesses presented on
    // the cycle reset releases are dropped even when no fill is performed.
    assign rd_go = resetn && init_done && ren;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY:   init_done <= 1'b1;
                default: state <= READY;
            endcase
        end
    end

    // The zero fill borrows the write port; user writes are locked out until ready.
    always_ff @(posedge clk) begin
        if (resetn && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (resetn && init_done) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (wen[i]) begin
                    mem[waddr][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[raddr];
        if (RDW_NEW && (|wen) && (waddr == raddr)) begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (wen[i]) begin
                    rd_word[i*COL_WIDTH +: COL_WIDTH] = wdata[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] pipe_data;
            logic                  pipe_valid;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    pipe_valid <= 1'b0;
                    rvalid     <= 1'b0;
                    rdata      <= '0;
                end else begin
                    pipe_valid <= rd_go;
                    if (rd_go) begin
                        pipe_data <= rd_word;
                    end
                    rvalid <= pipe_valid;
                    if (pipe_valid) begin
                        rdata <= pipe_data;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    rvalid <= 1'b0;
                    rdata  <= '0;
                end else begin
                    rvalid <= rd_go;
                    if (rd_go) begin
                        rdata <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bytewrite_sdp_ram_clr.sv
// Drives four differently configured RAMs with shared stimulus and checks each
// cycle against a word-level memory model plus a table of directed vectors.
module tb_bytewrite_sdp_ram_clr;
    localparam int NI    = 4;
    localparam int DW    = 128;
    localparam int AW    = 8;
    localparam int NC    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NC-1:0] wen = '0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ren = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata_o  [NI];
    logic          rvalid_o [NI];
    logic          init_o   [NI];

    always #5 clk = ~clk;

    bytewrite_sdp_ram_clr #(.READ_LATENCY(1), .RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)) ua (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren),
        .raddr(raddr), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .init_done(init_o[0]));
    bytewrite_sdp_ram_clr #(.READ_LATENCY(2), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) ub (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren),
        .raddr(raddr), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .init_done(init_o[1]));
    bytewrite_sdp_ram_clr #(.READ_LATENCY(1), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b0)) uc (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren),
        .raddr(raddr), .rdata(rdata_o[2]), .rvalid(rvalid_o[2]), .init_done(init_o[2]));
    bytewrite_sdp_ram_clr #(.READ_LATENCY(2), .RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)) ud (
        .clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren),
        .raddr(raddr), .rdata(rdata_o[3]), .rvalid(rvalid_o[3]), .init_done(init_o[3]));

    function automatic int lat_of(input int k);
        return (k == 1 || k == 3) ? 2 : 1;
    endfunction
    function automatic bit rdw_of(input int k);
        return (k == 1 || k == 2);
    endfunction
    function automatic bit clr_of(input int k);
        return (k != 2);
    endfunction

    typedef struct {
        logic [NC-1:0] wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          ren;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_old;
        logic [DW-1:0] exp_new;
    } vec_t;
    vec_t vecs[$];

    // Model: memory words with per-column "known" flags (un-cleared RAM is undefined),
    // and expected read results keyed by the edge at which they must appear.
    logic [DW-1:0] m_mem   [NI][DEPTH];
    logic [NC-1:0] m_known [NI][DEPTH];
    bit            m_acc   [NI];
    bit            m_clring[NI];
    int            m_clr   [NI];
    bit            e_v     [NI][4];
    logic [DW-1:0] e_d     [NI][4];
    logic [NC-1:0] e_m     [NI][4];
    logic [DW-1:0] last_d  [NI];
    logic [NC-1:0] last_m  [NI];
    int            edge_n = 0;
    bit            started = 1'b0;
    bit            tab_on = 1'b0;
    logic [DW-1:0] tab_old, tab_new;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NC-1:0] en);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NC; i++) if (en[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic void cmp(input string name, input int k, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp, input logic [NC-1:0] cmask);
        logic [DW-1:0] bm;
        for (int i = 0; i < NC; i++) bm[i*8 +: 8] = {8{cmask[i]}};
        checks++;
        if (((act ^ exp) & bm) !== '0) begin
            errors++;
            $display("[TB] FAIL %s inst%0d: got %h, expected %h", name, k, act, exp);
        end
    endfunction

    function automatic void modelEdge();
        logic [DW-1:0] rd;
        logic [NC-1:0] rm;
        int slot;
        edge_n++;
        for (int k = 0; k < NI; k++) begin
            if (!resetn) begin
                m_acc[k]    = 1'b0;
                m_clring[k] = clr_of(k);
                m_clr[k]    = 0;
                for (int s = 0; s < 4; s++) e_v[k][s] = 1'b0;
                last_d[k] = '0;
                last_m[k] = '1;
            end else if (m_clring[k]) begin
                m_mem[k][m_clr[k]]   = '0;
                m_known[k][m_clr[k]] = '1;
                m_clr[k]++;
                if (m_clr[k] == DEPTH) begin
                    m_clring[k] = 1'b0;
                    m_acc[k]    = 1'b1;
                end
            end else if (!m_acc[k]) begin
                m_acc[k] = 1'b1;
            end else begin
                if (ren) begin
                    rd = m_mem[k][raddr];
                    rm = m_known[k][raddr];
                    if (rdw_of(k) && wen != '0 && waddr == raddr) begin
                        rd = merge(rd, wdata, wen);
                        rm = rm | wen;
                    end
                    if (tab_on && clr_of(k)) rd = rdw_of(k) ? tab_new : tab_old;
                    slot = (edge_n + lat_of(k) - 1) % 4;
                    e_v[k][slot] = 1'b1;
                    e_d[k][slot] = rd;
                    e_m[k][slot] = rm;
                end
                if (wen != '0) begin
                    m_mem[k][waddr]   = merge(m_mem[k][waddr], wdata, wen);
                    m_known[k][waddr] = m_known[k][waddr] | wen;
                end
            end
        end
        if (!resetn) started = 1'b1;
    endfunction

    function automatic void checkOutput();
        int slot;
        slot = edge_n % 4;
        if (!started) return;
        for (int k = 0; k < NI; k++) begin
            cmp("init_done", k, DW'(init_o[k]), DW'(m_acc[k]), 1);
            cmp("rvalid", k, DW'(rvalid_o[k]), DW'(e_v[k][slot]), 1);
            if (e_v[k][slot]) begin
                last_d[k]      = e_d[k][slot];
                last_m[k]      = e_m[k][slot];
                e_v[k][slot]   = 1'b0;
            end
            cmp("rdata", k, rdata_o[k], last_d[k], last_m[k]);
        end
    endfunction

    task automatic applyStimulus(input logic rst_n, input logic [NC-1:0] w_en, input logic [AW-1:0] w_a,
                                 input logic [DW-1:0] w_d, input logic r_en, input logic [AW-1:0] r_a);
        resetn = rst_n;
        wen    = w_en;
        waddr  = w_a;
        wdata  = w_d;
        ren    = r_en;
        raddr  = r_a;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic randomCycle(input int amax);
        logic [NC-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = '0;
            1:       w = '1;
            default: w = NC'($urandom);
        endcase
        applyStimulus(1'b1, w, AW'($urandom_range(0, amax)), {$urandom, $urandom, $urandom, $urandom},
                      1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)));
    endtask

    task automatic addVec(input logic [NC-1:0] w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic r, input logic [AW-1:0] ra, input logic [DW-1:0] eo,
                          input logic [DW-1:0] en);
        vec_t v;
        v = '{w, wa, wd, r, ra, eo, en};
        vecs.push_back(v);
    endtask

    initial begin
        int  cnt;
        bit  seen;
        logic [1:0] la, lb;

        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[k][a]   = '0;
                m_known[k][a] = '0;
            end
            for (int s = 0; s < 4; s++) e_v[k][s] = 1'b0;
            m_acc[k] = 1'b0; m_clring[k] = 1'b0; m_clr[k] = 0;
            last_d[k] = '0; last_m[k] = '1;
        end

        addVec('0, '0, '0, 1'b1, 8'h00, '0, '0);
        addVec('0, '0, '0, 1'b1, 8'h7F, '0, '0);
        addVec('0, '0, '0, 1'b1, 8'hFF, '0, '0);
        addVec('1, 8'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, '0, '0, '0);
        addVec(16'h0001, 8'h10, 128'hA5, 1'b0, '0, '0, '0);
        addVec('0, '0, '0, 1'b1, 8'h10, 128'h00112233_44556677_8899AABB_CCDDEEA5,
               128'h00112233_44556677_8899AABB_CCDDEEA5);
        addVec('1, 8'h20, 128'h1, 1'b0, '0, '0, '0);
        addVec('1, 8'h20, 128'h2, 1'b1, 8'h20, 128'h1, 128'h2);
        addVec('0, '0, '0, 1'b1, 8'h20, 128'h2, 128'h2);
        for (int a = 0; a < 8; a++) addVec('1, AW'(a), DW'(a), 1'b0, '0, '0, '0);
        for (int a = 0; a < 8; a++) addVec('0, '0, '0, 1'b1, AW'(a), DW'(a), DW'(a));
        for (int a = 0; a < 3; a++) addVec('0, '0, '0, 1'b0, '0, '0, '0);

        repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);

        // Fill phase with random traffic that the cleared instances must ignore.
        cnt = 0;
        while (!init_o[0] && cnt < 300) begin
            randomCycle(255);
            cnt++;
            if (cnt == 1) begin
                cmp("noclear_init_first", 2, DW'(init_o[2]), DW'(1), 1);
                cmp("clear_init_first", 0, DW'(init_o[0]), DW'(0), 1);
            end
        end
        cmp("clear_cycles", 0, DW'(cnt), DW'(256), '1);

        foreach (vecs[i]) begin
            tab_on  = vecs[i].ren;
            tab_old = vecs[i].exp_old;
            tab_new = vecs[i].exp_new;
            applyStimulus(1'b1, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ren, vecs[i].raddr);
        end
        tab_on = 1'b0;
        cmp("stream_hold", 0, rdata_o[0], DW'(7), '1);
        cmp("stream_hold", 1, rdata_o[1], DW'(7), '1);

        applyStimulus(1'b1, '0, '0, '0, 1'b1, 8'h10);
        la[1] = rvalid_o[0]; lb[1] = rvalid_o[1];
        applyStimulus(1'b1, '0, '0, '0, 1'b0, '0);
        la[0] = rvalid_o[0]; lb[0] = rvalid_o[1];
        applyStimulus(1'b1, '0, '0, '0, 1'b0, '0);
        cmp("latency1", 0, DW'(la), DW'(2'b10), 1);
        cmp("latency2", 1, DW'(lb), DW'(2'b01), 1);

        repeat (400) randomCycle(15);

        // Reset part-way through the fill: it must restart from entry 0.
        repeat (2) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        repeat (100) randomCycle(255);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        cnt = 0;
        while (!init_o[1] && cnt < 300) begin
            randomCycle(255);
            cnt++;
        end
        cmp("refill_cycles", 1, DW'(cnt), DW'(256), '1);

        repeat (20) randomCycle(15);

        applyStimulus(1'b1, '0, '0, '0, 1'b1, 8'h03);
        applyStimulus(1'b1, '0, '0, '0, 1'b1, 8'h04);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        seen = 1'b0;
        repeat (4) begin
            applyStimulus(1'b1, '0, '0, '0, 1'b0, '0);
            if (rvalid_o[1] || rvalid_o[3]) seen = 1'b1;
        end
        cmp("squash_rvalid", 1, DW'(seen), DW'(0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
